// File: rtl/gridx_mem_pkg.sv
// ============================================================================
// gridx_mem_pkg : shared types and helpers for the bank request issuer
// Rev 1.0
// ============================================================================
`default_nettype none

package gridx_mem_pkg;

    localparam int DEF_NUM_WARPS        = 2;
    localparam int DEF_THREADS_PER_WARP = 4;
    localparam int DEF_NUM_BANKS        = 8;
    localparam int DEF_ADDR_BITS        = 8;
    localparam int DEF_MAX_ROUNDS       = 16;
    localparam int BANK_BITS            = $clog2(DEF_NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } issuer_state_t;

    function automatic logic [BANK_BITS-1:0] bank_of(input logic [DEF_ADDR_BITS-1:0] addr);
        return addr[BANK_BITS-1:0];
    endfunction

    function automatic int warp_of(input int thread);
        return thread / DEF_THREADS_PER_WARP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/warp_issue_fsm.sv
// ============================================================================
// warp_issue_fsm : one warp's issue/replay sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module warp_issue_fsm
    import gridx_mem_pkg::*;
#(
    parameter int THREADS    = DEF_THREADS_PER_WARP,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_write,
    input  logic [THREADS-1:0]   cmd_thread_mask,
    input  logic [ADDR_BITS-1:0] cmd_addr [THREADS],
    output logic [THREADS-1:0]   request_valid,
    output logic [BANK_BITS-1:0] request_bank [THREADS],
    output logic                 request_is_write,
    input  logic [THREADS-1:0]   grant,
    output logic [THREADS-1:0]   thread_granted,
    output logic                 done_valid,
    output logic [7:0]           replay_count,
    output logic                 timeout_err,
    output logic                 in_resp,
    output logic [THREADS-1:0]   resp_pending
);

    issuer_state_t        r_state;
    logic [THREADS-1:0]   r_pending;
    logic [BANK_BITS-1:0] r_bank [THREADS];
    logic                 r_is_write;
    logic [7:0]           r_replay;
    logic                 r_timeout;

    logic [THREADS-1:0]   w_pending_next;
    logic                 w_round_limit;
    logic                 w_unused_addr;

    assign w_pending_next = r_pending & ~grant;
    assign w_round_limit  = ({1'b0, r_replay} + 9'd1) == 9'(MAX_ROUNDS);

    // Only the bank bits of each address matter once latched.
    always_comb begin
        w_unused_addr = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            w_unused_addr = w_unused_addr ^ (^cmd_addr[t][ADDR_BITS-1:BANK_BITS]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_is_write <= 1'b0;
            r_replay   <= '0;
            r_timeout  <= 1'b0;
            for (int t = 0; t < THREADS; t++) begin
                r_bank[t] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_pending  <= cmd_thread_mask;
                        r_is_write <= cmd_is_write;
                        r_replay   <= '0;
                        for (int t = 0; t < THREADS; t++) begin
                            r_bank[t] <= bank_of(cmd_addr[t]);
                        end
                        r_state <= (cmd_thread_mask == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: r_state <= RESP;
                RESP: begin
                    r_pending <= w_pending_next;
                    if (w_pending_next == '0) begin
                        r_state <= DONE;
                    end else begin
                        if (r_replay != 8'hFF) begin
                            r_replay <= r_replay + 8'd1;
                        end
                        // Timeout only flags; the replay keeps going.
                        if (w_round_limit) begin
                            r_timeout <= 1'b1;
                        end
                        r_state <= ISSUE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready        = (r_state == IDLE);
    assign done_valid       = (r_state == DONE);
    assign in_resp          = (r_state == RESP);
    assign request_valid    = (r_state == ISSUE) ? r_pending : '0;
    assign thread_granted   = (r_state == RESP) ? (r_pending & grant) : '0;
    assign resp_pending     = (r_state == RESP) ? r_pending : '0;
    assign request_is_write = r_is_write;
    assign replay_count     = r_replay;
    assign timeout_err      = r_timeout;

    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            request_bank[t] = r_bank[t];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bank_request_issuer.sv
// ============================================================================
// bank_request_issuer : per-warp request issue and conflict replay
// Rev 1.0
// ============================================================================
`default_nettype none

module bank_request_issuer
    import gridx_mem_pkg::*;
#(
    parameter int NUM_WARPS        = DEF_NUM_WARPS,
    parameter int THREADS_PER_WARP = DEF_THREADS_PER_WARP,
    parameter int NUM_REQUESTERS   = NUM_WARPS * THREADS_PER_WARP,
    parameter int NUM_BANKS        = DEF_NUM_BANKS,
    parameter int ADDR_BITS        = DEF_ADDR_BITS,
    parameter int MAX_ROUNDS       = DEF_MAX_ROUNDS,
    localparam int BANK_W          = $clog2(NUM_BANKS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_WARPS-1:0]      cmd_valid,
    output logic [NUM_WARPS-1:0]      cmd_ready,
    input  logic [NUM_WARPS-1:0]      cmd_is_write,
    input  logic [NUM_REQUESTERS-1:0] cmd_thread_mask,
    input  logic [ADDR_BITS-1:0]      cmd_addr [NUM_REQUESTERS-1:0],
    output logic [NUM_REQUESTERS-1:0] request_valid,
    output logic [BANK_W-1:0]         request_bank [NUM_REQUESTERS-1:0],
    output logic [NUM_REQUESTERS-1:0] request_is_write,
    input  logic [NUM_REQUESTERS-1:0] grant,
    input  logic [NUM_REQUESTERS-1:0] bank_conflict,
    output logic [NUM_REQUESTERS-1:0] thread_granted,
    output logic [NUM_WARPS-1:0]      done_valid,
    output logic [7:0]                replay_count [NUM_WARPS-1:0],
    output logic [NUM_WARPS-1:0]      timeout_err,
    output logic                      protocol_err
);

    logic [NUM_WARPS-1:0]      w_in_resp;
    logic [NUM_REQUESTERS-1:0] w_thr_in_resp;
    logic [NUM_REQUESTERS-1:0] w_resp_pending;
    logic [NUM_REQUESTERS-1:0] w_violation;
    logic                      r_protocol_err;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [ADDR_BITS-1:0] w_addr [THREADS_PER_WARP];
        logic [BANK_BITS-1:0] w_bank [THREADS_PER_WARP];
        logic                 w_is_write;

        for (genvar t = 0; t < THREADS_PER_WARP; t++) begin : g_thread
            assign w_addr[t] = cmd_addr[w*THREADS_PER_WARP + t];
            assign request_bank[w*THREADS_PER_WARP + t]     = w_bank[t];
            assign request_is_write[w*THREADS_PER_WARP + t] = w_is_write;
        end

        warp_issue_fsm #(
            .THREADS    (THREADS_PER_WARP),
            .ADDR_BITS  (ADDR_BITS),
            .MAX_ROUNDS (MAX_ROUNDS)
        ) u_fsm (
            .clk              (clk),
            .reset_n          (reset_n),
            .cmd_valid        (cmd_valid[w]),
            .cmd_ready        (cmd_ready[w]),
            .cmd_is_write     (cmd_is_write[w]),
            .cmd_thread_mask  (cmd_thread_mask[w*THREADS_PER_WARP +: THREADS_PER_WARP]),
            .cmd_addr         (w_addr),
            .request_valid    (request_valid[w*THREADS_PER_WARP +: THREADS_PER_WARP]),
            .request_bank     (w_bank),
            .request_is_write (w_is_write),
            .grant            (grant[w*THREADS_PER_WARP +: THREADS_PER_WARP]),
            .thread_granted   (thread_granted[w*THREADS_PER_WARP +: THREADS_PER_WARP]),
            .done_valid       (done_valid[w]),
            .replay_count     (replay_count[w]),
            .timeout_err      (timeout_err[w]),
            .in_resp          (w_in_resp[w]),
            .resp_pending     (w_resp_pending[w*THREADS_PER_WARP +: THREADS_PER_WARP])
        );
    end

    for (genvar j = 0; j < NUM_REQUESTERS; j++) begin : g_thr_resp
        localparam int WJ = warp_of(j);
        assign w_thr_in_resp[j] = w_in_resp[WJ];
    end

    // A response is only legal in the cycle after its warp issued, and a
    // grant only for a thread that actually requested.
    assign w_violation = (bank_conflict & ~w_thr_in_resp)
                       | (grant & ~w_resp_pending)
                       | (grant & bank_conflict);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_protocol_err <= 1'b0;
        end else if (|w_violation) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err = r_protocol_err;

endmodule

`default_nettype wire
